fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupling buffer between instruction fetch and decode. Each cycle, fetch presents a (pc, instruction) pair read at the program counter's current address. The queue stores up to DEPTH pairs in order and hands them to decode through a valid/ready handshake. It absorbs decode stalls without freezing the PC, and is emptied in one cycle by a redirect flush on a taken branch or jump.

## Interface
- PC_WIDTH, 32: width of stored PC.
- INSTR_WIDTH, 32: width of stored instruction word.
- DEPTH, 4: number of entries; power of two, 2..16.
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  reset, synchronous, active-high.
- flush  input  1  redirect; discard all entries at the next edge.
- in_valid  input  1  fetch offers an entry.
- in_ready  output  1  queue accepts the entry this cycle.
- in_pc  input  PC_WIDTH  PC of the offered instruction.
- in_instr  input  INSTR_WIDTH  offered instruction word.
- out_valid  output  1  head entry available to decode.
- out_ready  input  1  decode consumes the head entry this cycle.
- out_pc  output  PC_WIDTH  PC of the head entry.
- out_instr  output  INSTR_WIDTH  instruction of the head entry.
- count  output  $clog2(DEPTH+1)  number of stored entries.

## Operation
- State consists of the storage array, read pointer rd_ptr, write pointer wr_ptr (each $clog2(DEPTH) bits, wrapping modulo DEPTH), and count.
- Handshake signals:
  - in_ready = (count != DEPTH) && !flush.
  - out_valid = (count != 0) && !flush.
  - Both are combinational from state and flush only. There is no combinational path from out_ready to in_ready and no bypass from in_* to out_*.
- Transfers:
  - Push when in_valid && in_ready: write entry at wr_ptr, advance wr_ptr.
  - Pop when out_valid && out_ready: advance rd_ptr.
  - Simultaneous push and pop leaves count unchanged. Push only increments count; pop only decrements it.
- Output data:
  - When count != 0, out_pc and out_instr show the head entry.
  - When count == 0, they show RESET_PC (32'hBFC00000) and NOP_INSTR (32'h00000013).
- Flush:
  - At the edge where flush is high, rd_ptr, wr_ptr and count are set to 0.
  - Any push or pop offered in that cycle is ignored, because in_ready and out_valid are masked low.
  - Fetch resubmits from the redirected PC on the following cycles.
- Reset:
  - rst has priority over flush and over all transfers.
  - After reset: pointers and count are 0, in_ready=1, out_valid=0, out_pc=32'hBFC00000, out_instr=32'h00000013, count=0.
  - Reset asserted mid-stream discards all entries.
- Storage is not reset. Its contents are only observable through a valid head entry.

## Timing
- Write-to-read latency is 1 cycle. An entry pushed at edge N is presented with out_valid=1 after edge N, and can be popped at edge N+1 at the earliest.
- Sustained throughput is one entry per cycle when out_ready is held high.
- When full, in_ready=0 even if out_ready=1 in the same cycle. The slot frees after the pop edge, so fetch sees in_ready=1 in the next cycle.
- Pointer wrap from DEPTH-1 to 0 is seamless. Order is preserved across the wrap.
- A flush takes effect in one cycle. In the flush cycle itself both out_valid and in_ready read 0.

## Structure
- Shared package fetch_pkg holds:
  - RESET_PC = 32'hBFC00000, also used by the PC reset.
  - NOP_INSTR = 32'h00000013 (addi x0,x0,0).
  - typedef fetch_entry_t: packed struct {pc, instr}.
- Single module, no sub-modules. Storage is an array of fetch_entry_t, inferred as registers (DEPTH is small).

## Test plan
- Reset then idle: out_valid=0, in_ready=1, count=0, out_pc=32'hBFC00000, out_instr=32'h00000013.
- Fill with out_ready=0: push pc 0xBFC00000/0x..04/0x..08/0x..0C with instrs 0x00100093..0x00400093. After the 4th push, in_ready=0 and count=4. A 5th in_valid is not accepted.
- Drain and wrap: continuous push and pop for 10 cycles with out_ready=1. Decode receives PCs in strict +4 order with no gaps or duplicates, count stays 1, and the pointers wrap twice.
- Backpressure toggle: randomly gate out_ready 50% over 200 pushes. Output order matches input order exactly, and count never exceeds 4.
- Flush: with 3 entries queued, assert flush together with in_valid and out_ready. In that cycle out_valid=0 and in_ready=0. Next cycle count=0. Pushing pc 0xBFC00100 then yields out_pc=0xBFC00100 one cycle later.
- Reset mid-operation: with 2 entries queued, assert rst together with flush and in_valid. Next cycle all reset values hold, and no stale entry ever appears on out_*.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared fetch-path definitions: reset vector, canonical NOP, and the
// (pc, instr) pair stored by the fetch queue.
package fetch_pkg;

  localparam int FETCH_PC_W    = 32;
  localparam int FETCH_INSTR_W = 32;

  // Boot vector; the PC register resets here and the empty queue shows it.
  localparam logic [FETCH_PC_W-1:0]    RESET_PC  = 32'hBFC00000;
  // addi x0,x0,0 -- harmless word presented when nothing is queued.
  localparam logic [FETCH_INSTR_W-1:0] NOP_INSTR = 32'h00000013;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]    pc;
    logic [FETCH_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Fetch-to-decode decoupling buffer. Circular buffer of DEPTH entries with
// valid/ready on both sides and a single-cycle redirect flush. Handshake
// outputs depend only on registered state and flush, so there is no path
// from out_ready to in_ready and no in_* to out_* bypass.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int PC_WIDTH    = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int DEPTH       = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [PC_WIDTH-1:0]        in_pc,
  input  logic [INSTR_WIDTH-1:0]     in_instr,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [PC_WIDTH-1:0]        out_pc,
  output logic [INSTR_WIDTH-1:0]     out_instr,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count_q;
  fetch_entry_t     mem [DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  assign full      = (count_q == CNT_W'(DEPTH));
  assign empty     = (count_q == '0);
  // Flush masks both handshakes so nothing moves in the redirect cycle.
  assign in_ready  = !full && !flush;
  assign out_valid = !empty && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;

  // Pointer and occupancy update; reset beats flush beats transfers.
  // DEPTH is a power of two, so pointers wrap naturally on overflow.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else if (flush) begin
      rd_ptr  <= '0;
      wr_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end

  // Entry storage; not reset, only visible through a valid head entry.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem[wr_ptr].pc    <= FETCH_PC_W'(in_pc);
      mem[wr_ptr].instr <= FETCH_INSTR_W'(in_instr);
    end
  end

  // Head entry, or reset vector / NOP when empty so decode never sees stale data.
  always_comb begin
    out_pc    = PC_WIDTH'(RESET_PC);
    out_instr = INSTR_WIDTH'(NOP_INSTR);
    if (!empty) begin
      out_pc    = PC_WIDTH'(mem[rd_ptr].pc);
      out_instr = INSTR_WIDTH'(mem[rd_ptr].instr);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: reset, fill, drain/wrap, random
// backpressure with an in-order scoreboard, flush, and mid-stream reset.
module tb_fetch_queue;
  localparam logic [31:0] RPC = 32'hBFC00000;
  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [31:0] in_instr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic [2:0]  count;

  int total = 0;
  int bad   = 0;

  fetch_queue #(.PC_WIDTH(32), .INSTR_WIDTH(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_instr(in_instr),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_instr(out_instr),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance one edge and settle a little after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, ".in_ready"},  {31'd0, in_ready},  32'd1);
    check({tag, ".count"},     {29'd0, count},     32'd0);
    check({tag, ".out_pc"},    out_pc,             RPC);
    check({tag, ".out_instr"}, out_instr,          NOP);
  endtask

  logic [31:0] sb_q[$];
  logic [31:0] exp_pc;
  int          pushed;
  int          popped;
  int          cyc;
  bit          do_push;
  bit          do_pop;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    tick(); tick();
    rst = 1'b0;
    #1;
    check_reset_state("reset");

    // Fill with decode stalled.
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_pc    = RPC + 32'(4 * i);
      in_instr = 32'h00100093 + 32'(i) * 32'h00100000;
      #1;
      check("fill.in_ready", {31'd0, in_ready}, 32'd1);
      tick();
    end
    check("full.count",     {29'd0, count},     32'd4);
    check("full.in_ready",  {31'd0, in_ready},  32'd0);
    check("full.out_valid", {31'd0, out_valid}, 32'd1);
    check("full.out_pc",    out_pc,             RPC);
    check("full.out_instr", out_instr,          32'h00100093);
    in_pc = RPC + 32'h10; in_instr = 32'h00500093;
    tick();
    check("fifth.count",  {29'd0, count}, 32'd4);
    check("fifth.out_pc", out_pc,         RPC);

    // When full with decode ready, in_ready stays low until the pop edge.
    out_ready = 1'b1;
    #1;
    check("fullpop.in_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("afterpop.in_ready", {31'd0, in_ready}, 32'd1);
    check("afterpop.out_pc",   out_pc,            RPC + 32'h4);
    in_valid = 1'b0;
    for (int i = 1; i < 4; i++) begin
      check("drain.out_pc",    out_pc,    RPC + 32'(4 * i));
      check("drain.out_instr", out_instr, 32'h00100093 + 32'(i) * 32'h00100000);
      tick();
    end
    check_reset_state("drained");

    // Streaming push and pop: one entry in flight, pointers wrap twice.
    in_valid = 1'b1; in_pc = 32'h00001000; in_instr = 32'hA0000000;
    tick();
    for (int k = 0; k < 10; k++) begin
      in_pc    = 32'h00001000 + 32'(4 * (k + 1));
      in_instr = 32'hA0000000 + 32'(k + 1);
      check("stream.count",     {29'd0, count},     32'd1);
      check("stream.out_valid", {31'd0, out_valid}, 32'd1);
      check("stream.out_pc",    out_pc,             32'h00001000 + 32'(4 * k));
      check("stream.out_instr", out_instr,          32'hA0000000 + 32'(k));
      tick();
    end
    in_valid = 1'b0;
    check("stream.last_pc", out_pc, 32'h00001028);
    tick();
    check("stream.empty", {29'd0, count}, 32'd0);

    // Random backpressure against an in-order scoreboard.
    pushed = 0; popped = 0; cyc = 0;
    while (popped < 200 && cyc < 2000) begin
      in_valid  = (pushed < 200);
      in_pc     = 32'h20000000 + 32'(4 * pushed);
      in_instr  = ~(32'h20000000 + 32'(4 * pushed));
      out_ready = 1'($urandom_range(0, 1));
      #1;
      do_push = in_valid && in_ready;
      do_pop  = out_valid && out_ready;
      if (do_pop) begin
        exp_pc = sb_q.pop_front();
        check("bp.out_pc",    out_pc,    exp_pc);
        check("bp.out_instr", out_instr, ~exp_pc);
        popped++;
      end
      if (do_push) begin
        sb_q.push_back(in_pc);
        pushed++;
      end
      total++;
      assert (count <= 3'd4) else begin
        bad++;
        $error("FAIL bp.count_max: observed=%0d expected<=4", count);
      end
      tick();
      cyc++;
    end
    check("bp.popped", 32'(popped), 32'd200);
    in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("bp.empty", {29'd0, count}, 32'd0);

    // Flush with three entries queued and both sides trying to move.
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = 32'h30000000 + 32'(4 * i); in_instr = 32'h11110000 + 32'(i);
      tick();
    end
    check("preflush.count", {29'd0, count}, 32'd3);
    flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1; in_pc = 32'h3000000C;
    #1;
    check("flush.out_valid", {31'd0, out_valid}, 32'd0);
    check("flush.in_ready",  {31'd0, in_ready},  32'd0);
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    check("postflush.count",  {29'd0, count}, 32'd0);
    check("postflush.out_pc", out_pc,         RPC);
    in_valid = 1'b1; in_pc = 32'hBFC00100; in_instr = 32'h00A00093;
    tick();
    in_valid = 1'b0;
    check("redirect.out_valid", {31'd0, out_valid}, 32'd1);
    check("redirect.out_pc",    out_pc,             32'hBFC00100);
    check("redirect.out_instr", out_instr,          32'h00A00093);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("redirect.drained", {29'd0, count}, 32'd0);

    // Reset mid-stream wins over flush and a concurrent push.
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_pc = 32'h40000000 + 32'(4 * i); in_instr = 32'h22220000 + 32'(i);
      tick();
    end
    check("prerst.count", {29'd0, count}, 32'd2);
    rst = 1'b1; flush = 1'b1; in_valid = 1'b1; in_pc = 32'h40000008;
    tick();
    rst = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    #1;
    check_reset_state("midrst");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst.no_stale", {31'd0, out_valid}, 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
